// File: rtl/text_console_pkg.sv
// Shared constants, ASCII codes and FSM state encoding for the text console.
package text_console_pkg;

    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 16;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_SCREEN = 2'd1,
        CLR_LINE   = 2'd2
    } state_e;

    // True for bytes that are stored as glyphs.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_SPACE) && (b <= CH_TILDE);
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Character write handshake and cursor/status bundle.
interface text_console_ctrl_if;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;
    logic       busy;
    logic [6:0] cur_col;
    logic [4:0] cur_row;

    modport master (output ch_valid, ch_data, input ch_ready, busy, cur_col, cur_row);
    modport slave  (input ch_valid, ch_data, output ch_ready, busy, cur_col, cur_row);
endinterface

// File: rtl/text_console_ctrl_text_ram.sv
// Simple dual-port text RAM: one write port, one registered read port.
module text_ram #(
    parameter int unsigned DEPTH   = 2400,
    parameter int unsigned ADDR_W  = 12,
    parameter logic [7:0]  RD_INIT = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register; returns the old data on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= RD_INIT;
        else        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/text_console_ctrl.sv
// Text-mode console controller: byte writer with cursor/clears, 2-cycle glyph scanout.
// Optional underline blinking cursor: define TEXT_CONSOLE_CURSOR_EN.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int unsigned COLS      = 80,
    parameter int unsigned ROWS      = 30,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    text_console_ctrl_if.slave   ch_bus,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    input  logic                 de_in,
    output logic [7:0]           font_ascii,
    output logic [3:0]           font_row,
    input  logic [7:0]           font_data,
    output logic                 pix_on,
    output logic                 de_out
);
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE       = IDLE;
    localparam logic [1:0] ST_CLR_SCREEN = CLR_SCREEN;
    localparam logic [1:0] ST_CLR_LINE   = CLR_LINE;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W-1:0] clr_end_q, clr_end_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic              ready_q, busy_q;

    logic              we_c;
    logic [ADDR_W-1:0] waddr_c;
    logic [7:0]        wdata_c;
    logic              advance_c;
    logic [4:0]        row_nxt_c;
    logic [ADDR_W-1:0] cur_addr_c, line_base_c;

    assign cur_addr_c  = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    assign row_nxt_c   = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
    assign line_base_c = ADDR_W'(row_nxt_c) * ADDR_W'(COLS);

    // Next-state, cursor update and RAM write-port selection.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_end_d  = clr_end_q;
        col_d      = col_q;
        row_d      = row_q;
        we_c       = 1'b0;
        waddr_c    = cur_addr_c;
        wdata_c    = CH_SPACE;
        advance_c  = 1'b0;
        case (state_q)
            ST_CLR_SCREEN, ST_CLR_LINE: begin
                we_c    = 1'b1;
                waddr_c = clr_addr_q;
                if (clr_addr_q == clr_end_q) state_d = ST_IDLE;
                else                         clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
            default: begin
                if (ch_bus.ch_valid && ready_q) begin
                    if (is_printable(ch_bus.ch_data)) begin
                        we_c    = 1'b1;
                        wdata_c = ch_bus.ch_data;
                        if (col_q == 7'(COLS - 1)) begin
                            col_d     = 7'd0;
                            advance_c = 1'b1;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (ch_bus.ch_data)
                            CH_CR: col_d = 7'd0;
                            CH_LF: begin
                                col_d     = 7'd0;
                                advance_c = 1'b1;
                            end
                            CH_BS: begin
                                if (col_q != 7'd0) begin
                                    col_d   = col_q - 7'd1;
                                    we_c    = 1'b1;
                                    waddr_c = cur_addr_c - ADDR_W'(1);
                                end
                            end
                            CH_FF: begin
                                col_d      = 7'd0;
                                row_d      = 5'd0;
                                state_d    = ST_CLR_SCREEN;
                                clr_addr_d = '0;
                                clr_end_d  = ADDR_W'(DEPTH - 1);
                            end
                            default: ;
                        endcase
                    end
                    if (advance_c) begin
                        row_d      = row_nxt_c;
                        state_d    = ST_CLR_LINE;
                        clr_addr_d = line_base_c;
                        clr_end_d  = line_base_c + ADDR_W'(COLS - 1);
                    end
                end
            end
        endcase
    end

    // Write-side state; status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLR_SCREEN;
            clr_addr_q <= '0;
            clr_end_q  <= ADDR_W'(DEPTH - 1);
            col_q      <= 7'd0;
            row_q      <= 5'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_end_q  <= clr_end_d;
            col_q      <= col_d;
            row_q      <= row_d;
            ready_q    <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign ch_bus.ch_ready = ready_q;
    assign ch_bus.busy     = busy_q;
    assign ch_bus.cur_col  = col_q;
    assign ch_bus.cur_row  = row_q;

    // Scanout stage 0: cell lookup; out-of-area cells read address 0 and are masked.
    logic [6:0]        cell_col_c;
    logic [5:0]        cell_row_c;
    logic              in_bounds_c;
    logic [15:0]       rd_full_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              in_area_q, de_s0_q, pix_on_q, de_out_q;
    logic [2:0]        xbit_q;
    logic [3:0]        frow_q;
    logic              overlay_c;

    assign cell_col_c  = pix_x[9:3];
    assign cell_row_c  = pix_y[9:4];
    assign in_bounds_c = (cell_col_c < 7'(COLS)) && (cell_row_c < 6'(ROWS));
    assign rd_full_c   = 16'(cell_row_c) * 16'(COLS) + 16'(cell_col_c);
    assign rd_addr_c   = in_bounds_c ? ADDR_W'(rd_full_c) : '0;

    text_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_INIT(CH_SPACE)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (we_c),
        .waddr_i(waddr_c),
        .wdata_i(wdata_c),
        .raddr_i(rd_addr_c),
        .rdata_o(font_ascii)
    );

`ifdef TEXT_CONSOLE_CURSOR_EN
    logic [31:0] blink_cnt_q;
    logic        blink_q, cur_hit_q;

    // Free-running blink toggle every BLINK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= 32'd0;
            blink_q     <= 1'b0;
        end else if (blink_cnt_q == 32'(BLINK_DIV - 1)) begin
            blink_cnt_q <= 32'd0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end

    // Stage-0 match of the scanned cell against the cursor position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_hit_q <= 1'b0;
        else        cur_hit_q <= (cell_col_c == col_q) && (cell_row_c == {1'b0, row_q});
    end

    assign overlay_c = blink_q && cur_hit_q && in_area_q && (frow_q[3:1] == 3'b111);
`else
    assign overlay_c = 1'b0;
`endif

    // Stage-0 registers alongside the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_area_q <= 1'b0;
            de_s0_q   <= 1'b0;
            xbit_q    <= 3'd0;
            frow_q    <= 4'd0;
        end else begin
            in_area_q <= de_in && in_bounds_c;
            de_s0_q   <= de_in;
            xbit_q    <= pix_x[2:0];
            frow_q    <= pix_y[3:0];
        end
    end

    // Stage 1: pick the glyph bit, leftmost pixel is bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_on_q <= 1'b0;
            de_out_q <= 1'b0;
        end else begin
            pix_on_q <= (font_data[3'd7 - xbit_q] && in_area_q) || overlay_c;
            de_out_q <= de_s0_q;
        end
    end

    assign font_row = frow_q;
    assign pix_on   = pix_on_q;
    assign de_out   = de_out_q;
endmodule
